// File: rtl/index_decoder_if.sv
// Request/result bundle for the 256-entry index decoder and its bit mask.
// The master side issues requests and drains results; the slave side is the decoder.
interface index_decoder_if;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_idx;
    logic [1:0]   in_op;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_onehot;
    logic         out_hit;
    logic [255:0] mask;
    logic [8:0]   mask_count;

    modport slave (
        input  in_valid, in_idx, in_op, out_ready,
        output in_ready, out_valid, out_onehot, out_hit, mask, mask_count
    );

    modport master (
        output in_valid, in_idx, in_op, out_ready,
        input  in_ready, out_valid, out_onehot, out_hit, mask, mask_count
    );
endinterface

// File: rtl/index_decoder.sv
// One-hot index decoder with a 256-bit accumulated mask; result valid 1 cycle after accept.
// Single result register: in_ready = !out_valid | out_ready, so a stalled result blocks new requests.
module index_decoder (
    input  logic               clk,
    input  logic               rst,
    index_decoder_if.slave     bus
);
    localparam logic [1:0] OP_DECODE = 2'b00;
    localparam logic [1:0] OP_SET    = 2'b01;
    localparam logic [1:0] OP_CLR    = 2'b10;
    localparam logic [1:0] OP_CLRALL = 2'b11;

    typedef struct packed {
        logic [255:0] onehot;
        logic         hit;
    } result_t;

    logic         out_valid_q;
    result_t      result_q;
    logic [255:0] mask_q;
    logic [8:0]   count_q;

    logic         accept;
    logic         hit_bit;
    result_t      nxt_result;
    logic [255:0] nxt_mask;
    logic [8:0]   nxt_count;

    assign bus.in_ready = !out_valid_q | bus.out_ready;
    assign accept       = bus.in_valid & bus.in_ready;
    assign hit_bit      = mask_q[bus.in_idx];

    always_comb begin
        nxt_result.onehot              = '0;
        nxt_result.onehot[bus.in_idx]  = 1'b1;
        nxt_result.hit                 = hit_bit;
        nxt_mask                       = mask_q;
        nxt_count                      = count_q;
        case (bus.in_op)
            OP_DECODE: begin
                nxt_mask  = mask_q;
            end
            OP_SET: begin
                nxt_mask[bus.in_idx] = 1'b1;
                // Count only moves on an actual bit transition, so it tracks popcount exactly.
                if (!hit_bit) begin
                    nxt_count = count_q + 9'd1;
                end
            end
            OP_CLR: begin
                nxt_mask[bus.in_idx] = 1'b0;
                if (hit_bit) begin
                    nxt_count = count_q - 9'd1;
                end
            end
            default: begin
                nxt_result.onehot = '0;
                nxt_result.hit    = |mask_q;
                nxt_mask          = '0;
                nxt_count         = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            mask_q      <= '0;
            count_q     <= '0;
        end else if (accept) begin
            // Accept while draining keeps out_valid high and reloads: full throughput.
            out_valid_q <= 1'b1;
            result_q    <= nxt_result;
            mask_q      <= nxt_mask;
            count_q     <= nxt_count;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_onehot = result_q.onehot;
    assign bus.out_hit    = result_q.hit;
    assign bus.mask       = mask_q;
    assign bus.mask_count = count_q;
endmodule

// File: tb/tb_index_decoder.sv
// Directed vector table plus hand-written stall/reset sequences and a random run against a reference model.
module tb_index_decoder;
    localparam logic [1:0] OP_DECODE = 2'b00;
    localparam logic [1:0] OP_SET    = 2'b01;
    localparam logic [1:0] OP_CLR    = 2'b10;
    localparam logic [1:0] OP_CLRALL = 2'b11;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    index_decoder_if bus ();

    index_decoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [7:0]   idx;
        logic [255:0] exp_onehot;
        logic         exp_hit;
        logic [8:0]   exp_count;
        logic [255:0] exp_mask;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [255:0] bitv(input int i);
        logic [255:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [7:0] idx, input logic ordy);
        bus.in_valid  = v;
        bus.in_op     = op;
        bus.in_idx    = idx;
        bus.out_ready = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // reference model state for the random run
    logic [255:0] m_mask;
    logic [8:0]   m_count;
    logic         m_valid;
    logic [255:0] m_onehot;
    logic         m_hit;

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst       = 1'b1;
        drive(1'b0, OP_DECODE, 8'd0, 1'b1);
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_out_valid", 256'(bus.out_valid), 256'd0);
        check("rst_onehot", bus.out_onehot, 256'd0);
        check("rst_hit", 256'(bus.out_hit), 256'd0);
        check("rst_mask", bus.mask, 256'd0);
        check("rst_count", 256'(bus.mask_count), 256'd0);
        check("rst_in_ready", 256'(bus.in_ready), 256'd1);

        // Directed table: back-to-back accepts with out_ready held high
        vecs[0] = '{OP_DECODE, 8'd0,   bitv(0),   1'b0, 9'd0, 256'd0};
        vecs[1] = '{OP_DECODE, 8'd255, bitv(255), 1'b0, 9'd0, 256'd0};
        vecs[2] = '{OP_SET,    8'd5,   bitv(5),   1'b0, 9'd1, bitv(5)};
        vecs[3] = '{OP_SET,    8'd5,   bitv(5),   1'b1, 9'd1, bitv(5)};
        vecs[4] = '{OP_SET,    8'd200, bitv(200), 1'b0, 9'd2, bitv(5) | bitv(200)};
        vecs[5] = '{OP_CLR,    8'd5,   bitv(5),   1'b1, 9'd1, bitv(200)};
        vecs[6] = '{OP_CLR,    8'd7,   bitv(7),   1'b0, 9'd1, bitv(200)};
        vecs[7] = '{OP_DECODE, 8'd200, bitv(200), 1'b1, 9'd1, bitv(200)};
        vecs[8] = '{OP_CLRALL, 8'd3,   256'd0,    1'b1, 9'd0, 256'd0};
        vecs[9] = '{OP_CLRALL, 8'd9,   256'd0,    1'b0, 9'd0, 256'd0};
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].idx, 1'b1);
            step();
            check($sformatf("vec%0d_valid", i), 256'(bus.out_valid), 256'd1);
            check($sformatf("vec%0d_onehot", i), bus.out_onehot, vecs[i].exp_onehot);
            check($sformatf("vec%0d_hit", i), 256'(bus.out_hit), 256'(vecs[i].exp_hit));
            check($sformatf("vec%0d_count", i), 256'(bus.mask_count), 256'(vecs[i].exp_count));
            check($sformatf("vec%0d_mask", i), bus.mask, vecs[i].exp_mask);
        end
        drive(1'b0, OP_SET, 8'd1, 1'b1);
        step();
        check("drain_clears_valid", 256'(bus.out_valid), 256'd0);
        check("drain_mask_kept", bus.mask, 256'd0);

        // Backpressure: one accept, then a stalled request for 3 cycles
        drive(1'b1, OP_SET, 8'd10, 1'b0);
        step();
        check("bp_first_valid", 256'(bus.out_valid), 256'd1);
        drive(1'b1, OP_SET, 8'd11, 1'b0);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("bp%0d_in_ready", c), 256'(bus.in_ready), 256'd0);
            step();
            check($sformatf("bp%0d_onehot", c), bus.out_onehot, bitv(10));
            check($sformatf("bp%0d_count", c), 256'(bus.mask_count), 256'd1);
            check($sformatf("bp%0d_mask", c), bus.mask, bitv(10));
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 256'(bus.in_ready), 256'd1);
        step();
        check("bp_release_valid", 256'(bus.out_valid), 256'd1);
        check("bp_release_onehot", bus.out_onehot, bitv(11));
        check("bp_release_count", 256'(bus.mask_count), 256'd2);

        // Fill the whole mask back-to-back, then clear it in one request
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, OP_SET, i[7:0], 1'b1);
            step();
            check($sformatf("fill%0d_onehot", i), bus.out_onehot, bitv(i));
        end
        check("fill_mask", bus.mask, {256{1'b1}});
        check("fill_count", 256'(bus.mask_count), 256'd256);
        drive(1'b1, OP_CLRALL, 8'd77, 1'b1);
        step();
        check("clrall_hit", 256'(bus.out_hit), 256'd1);
        check("clrall_onehot", bus.out_onehot, 256'd0);
        check("clrall_mask", bus.mask, 256'd0);
        check("clrall_count", 256'(bus.mask_count), 256'd0);

        // Reset wins over a same-cycle accept while a result is held
        drive(1'b1, OP_SET, 8'd20, 1'b0);
        step();
        check("pre_rst_valid", 256'(bus.out_valid), 256'd1);
        drive(1'b1, OP_SET, 8'd9, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b0, OP_DECODE, 8'd0, 1'b0);
        #1;
        check("rst_pri_valid", 256'(bus.out_valid), 256'd0);
        check("rst_pri_mask", bus.mask, 256'd0);
        check("rst_pri_count", 256'(bus.mask_count), 256'd0);
        check("rst_pri_in_ready", 256'(bus.in_ready), 256'd1);

        // Random stream against the reference model
        m_mask   = '0;
        m_count  = '0;
        m_valid  = 1'b0;
        m_onehot = '0;
        m_hit    = 1'b0;
        for (int c = 0; c < 400; c++) begin
            logic       v;
            logic       ordy;
            logic [1:0] op;
            logic [7:0] idx;
            logic       exp_rdy;
            int         r;
            r   = $urandom_range(0, 19);
            op  = (r < 10) ? OP_SET : (r < 15) ? OP_CLR : (r < 19) ? OP_DECODE : OP_CLRALL;
            idx = 8'($urandom_range(0, 31));
            v   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            drive(v, op, idx, ordy);
            #1;
            exp_rdy = !m_valid | ordy;
            check("rnd_in_ready", 256'(bus.in_ready), 256'(exp_rdy));
            @(posedge clk);
            if (v && exp_rdy) begin
                m_valid = 1'b1;
                if (op == OP_CLRALL) begin
                    m_onehot = '0;
                    m_hit    = (m_mask != 0);
                    m_mask   = '0;
                end else begin
                    m_onehot = bitv(int'(idx));
                    m_hit    = m_mask[idx];
                    if (op == OP_SET)
                        m_mask[idx] = 1'b1;
                    else if (op == OP_CLR)
                        m_mask[idx] = 1'b0;
                end
                m_count = 9'($countones(m_mask));
            end else if (ordy) begin
                m_valid = 1'b0;
            end
            #1;
            check("rnd_valid", 256'(bus.out_valid), 256'(m_valid));
            check("rnd_onehot", bus.out_onehot, m_onehot);
            check("rnd_hit", 256'(bus.out_hit), 256'(m_hit));
            check("rnd_mask", bus.mask, m_mask);
            check("rnd_count", 256'(bus.mask_count), 256'(m_count));
            check("rnd_popcount", 256'(bus.mask_count), 256'($countones(bus.mask)));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/index_decoder.md
INDEX_DECODER -- requirements
Module: index_decoder

Interface
REQ-001 Parameters SHALL be none; the vector width is fixed at 256 bits and the index width at 8 bits.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 in_valid  in  1  request present.
REQ-005 in_ready  out  1  block can accept a request this cycle.
REQ-006 in_idx  in  8  bit index 0..255.
REQ-007 in_op  in  2  00 DECODE, 01 SET, 10 CLR, 11 CLRALL.
REQ-008 out_valid  out  1  result register holds an undelivered result.
REQ-009 out_ready  in  1  consumer takes the result this cycle.
REQ-010 out_onehot  out  256  registered one-hot decode of the accepted index.
REQ-011 out_hit  out  1  mask bit at the index before the update.
REQ-012 mask  out  256  accumulated bit mask, registered.
REQ-013 mask_count  out  9  number of set bits in mask, 0..256.

Function
REQ-014 in_ready SHALL equal (!out_valid | out_ready), combinationally.
REQ-015 Accept SHALL be defined as in_valid & in_ready; no other condition SHALL change state.
REQ-016 On accept, out_valid SHALL be 1 in the next cycle; latency SHALL be exactly 1 cycle.
REQ-017 On accept with op DECODE, SET or CLR, out_onehot SHALL be set to the 256-bit vector with only bit in_idx set.
REQ-018 On accept with op CLRALL, out_onehot SHALL be set to 0 and out_hit SHALL be set to (mask != 0); in_idx SHALL be ignored.
REQ-019 On accept with any other op, out_hit SHALL be set to mask[in_idx] as sampled before the update.
REQ-020 DECODE SHALL leave mask and mask_count unchanged.
REQ-021 SET SHALL set mask[in_idx]; mask_count SHALL increment only if the bit was 0.
REQ-022 CLR SHALL clear mask[in_idx]; mask_count SHALL decrement only if the bit was 1.
REQ-023 CLRALL SHALL set mask and mask_count to 0 in the same cycle.
REQ-024 mask_count SHALL always equal the popcount of mask; it SHALL never wrap (0..256 in 9 bits).
REQ-025 out_valid & out_ready without a same-cycle accept SHALL clear out_valid.
REQ-026 A same-cycle accept and drain SHALL keep out_valid at 1 and load the new result, giving full throughput of 1 request per cycle.
REQ-027 While out_valid & !out_ready, out_onehot and out_hit SHALL hold stable and in_ready SHALL be 0.
REQ-028 in_idx and in_op SHALL be ignored when in_valid is 0.

Reset
REQ-029 On rst=1 at a rising edge, out_valid, out_onehot, out_hit, mask and mask_count SHALL all become 0.
REQ-030 rst SHALL take priority over a same-cycle accept; that request SHALL be dropped.
REQ-031 A held, undelivered result SHALL be discarded on reset.
REQ-032 in_ready SHALL be 1 in the first cycle after reset, given out_valid=0.

Verification
REQ-033 Reset, then DECODE idx=0, then DECODE idx=255 with out_ready=1 -> out_onehot = bit 0, then bit 255, each 1 cycle after accept; mask stays 0; out_hit=0.
REQ-034 SET 5, SET 5, SET 200, CLR 5, CLR 7 -> mask_count sequence 1,1,2,1,1; out_hit sequence 0,1,0,1,0; final mask bit 200 only.
REQ-035 Hold out_ready=0 with in_valid=1 for 3 cycles after one accept -> in_ready=0, out_onehot stable, only 1 mask update; set out_ready=1 -> next request accepted same cycle, out_valid stays 1.
REQ-036 SET all 256 indices back-to-back -> mask all ones, mask_count=256; CLRALL -> out_hit=1, out_onehot=0, mask=0, mask_count=0 next cycle.
REQ-037 Assert rst in the same cycle as an accepted SET 9 while out_valid=1 -> next cycle out_valid=0, mask=0, mask_count=0, in_ready=1.
REQ-038 Random op, index and out_ready stream against a reference model -> mask, mask_count, out_onehot and out_hit match every cycle; mask_count equals popcount(mask).
